tile_pixel_writer: RTL and testbench
====================================

# tile_pixel_writer

Downstream stage of the tile solver: consumes its per-pixel `(address, 16-bit iteration count)` write stream and emits 32-bit memory-mapped writes with byte enables. It merges two adjacent pixels that share a 32-bit word into one write. A show-ahead FIFO decouples the solver from memory `waitrequest` stalls. It sits between the tile solver output and the frame-buffer bus master.

## Interface
Parameters:
- `FIFO_DEPTH_BITS`, default 3 — FIFO holds 2^`FIFO_DEPTH_BITS` entries. Minimum value is 2.

Ports:
- `clock` input 1 — clock.
- `reset` input 1 — synchronous, active-high.
- `in_addr` input 32 — pixel byte address. Bit 0 is ignored and is always 0 from the solver.
- `in_data` input 16 — iteration count.
- `in_valid` input 1 — pixel present.
- `in_ready` output 1 — pixel accepted when `in_valid && in_ready`.
- `flush` input 1 — single-cycle request to emit a held half-word.
- `mem_address` output 32 — word address `{addr[31:2],2'b00}`.
- `mem_writedata` output 32 — write data.
- `mem_byteenable` output 4 — byte enables.
- `mem_write` output 1 — write request.
- `mem_waitrequest` input 1 — slave stall.
- `busy` output 1 — any data held or queued.
- `words_written` output 32 — count of completed memory writes, wraps at 2^32.

## Operation
- FIFO entry is `{word address, 32-bit data, 4-bit byte enable}`. Push and pop may happen in the same cycle. `free` is the number of empty slots, counted before this cycle's pop.
- Packer state `EMPTY` or `HALF`. In `HALF` it holds `hold_addr`/`hold_data`, which is always a low half (`addr[1]=0`).
- `in_ready = !reset && !flush_req && free >= 2`. The 2-slot margin covers the worst case of two pushes.
- Accepted pixel in `EMPTY`:
  - `addr[1]=0` → go to `HALF`. Nothing is pushed.
  - `addr[1]=1` → push `{addr, {in_data,16'h0}, 4'b1100}`.
- Accepted pixel in `HALF`:
  - If `in_addr == hold_addr+2` → push `{hold_addr, {in_data,hold_data}, 4'b1111}` and go to `EMPTY`.
  - Otherwise → push `{hold_addr, {16'h0,hold_data}, 4'b0011}`, then treat the new pixel as in `EMPTY`. A second push happens this cycle if its `addr[1]=1`. FIFO is dual-push capable, or uses an equivalent 2-deep skid.
- `flush` sets `flush_req`. While `flush_req` is set:
  - No input is accepted.
  - On the first cycle with `free >= 1`: if in `HALF`, push the held half with `4'b0011` and go to `EMPTY`; then clear `flush_req`.
  - `flush` in `EMPTY` clears `flush_req` one cycle later with no push.
  - `flush` while `flush_req` is already set has no additional effect.
- Memory side: `mem_write = !fifo_empty`. Address, data and byte enable come from the FIFO head. Pop when `mem_write && !mem_waitrequest`, which also increments `words_written`.
- Outputs must hold stable while `mem_waitrequest` is high.
- `busy = (state==HALF) || !fifo_empty || flush_req`.

## Timing
- Reset (synchronous) clears FIFO, packer to `EMPTY`, `flush_req` to 0 and `words_written` to 0.
- Reset values of outputs: `mem_write` 0, `mem_address`/`mem_writedata`/`mem_byteenable` 0, `busy` 0, `in_ready` 0 while reset is high and 1 on the first cycle after.
- Reset mid-burst discards all held and queued data. No partial write completes after the reset edge.
- Latency: the push at the edge ending accept cycle N gives `mem_write=1` in cycle N+1. A flush push performed in cycle F gives `mem_write` in F+1.
- Throughput: one memory write per cycle with `mem_waitrequest=0`. Merged stream sustains 2 pixels per write.
- Full: `in_ready` drops when `free < 2`. It rises the cycle after a pop restores `free >= 2`.
- Empty: `mem_write` is 0. Data, address and byte enable are don't-care but held at the last value.

## Configuration
- `TILE_PIXEL_WRITER_PACK_EN` defined: packing behaviour as above.
- `TILE_PIXEL_WRITER_PACK_EN` not defined:
  - Packer removed; state is always `EMPTY`.
  - Every accepted pixel pushes one entry with data `{in_data,in_data}` and byte enable `4'b1100` if `addr[1]` else `4'b0011`.
  - `in_ready = !reset && free >= 1`.
  - `flush` is accepted and ignored; `flush_req` is constant 0.

## Test plan
- Pixels `0x1000`/`0xAAAA`, `0x1002`/`0xBBBB`, no stall → one write `addr 0x1000`, `data 0xBBBBAAAA`, `be 1111` in the cycle after the second accept; `words_written=1`.
- Pixel `0x2000`/`0x0005`, then `0x2008`/`0x0007` → write `0x2000`/`0x00000005`/`be 0011`; `0x2008` held, `busy=1`. `flush` → write `0x2008`/`0x00000007`/`be 0011`; `busy=0`.
- Lone pixel `0x3002`/`0x1234` → immediate write `0x3000`/`0x12340000`/`be 1100`, no flush needed.
- Full tile of 1024 pixels from base `0x0` with `mem_waitrequest` high for 20 cycles mid-stream → `in_ready` low once `free < 2`, no write lost or duplicated, final `words_written=512`, memory image matches.
- Reset asserted while `HALF` and 3 FIFO entries are queued → next cycle `mem_write=0`, `busy=0`, `words_written=0`; no stale write appears afterwards.
- Build without `TILE_PIXEL_WRITER_PACK_EN`: pixels `0x1000`/`0xAAAA`, `0x1002`/`0xBBBB` → two writes: `0xAAAAAAAA`/`be 0011`, then `0xBBBBBBBB`/`be 1100`, both at `0x1000`.

Source files
------------

// File: rtl/tile_pixel_writer.sv
// tile_pixel_writer: packs 16-bit pixel writes into 32-bit bus writes behind a show-ahead FIFO.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   in_addr/in_data       - pixel byte address (bit 0 ignored) and iteration count
//   in_valid/in_ready     - pixel handshake
//   flush                 - single-cycle request to emit a held low half-word
//   mem_address/writedata - word address and data of the FIFO head
//   mem_byteenable        - byte enables of the FIFO head
//   mem_write             - write request, mem_waitrequest stalls it
//   busy                  - any data held, queued or a flush pending
//   words_written         - completed memory writes, wrapping
// Build option: define TILE_PIXEL_WRITER_PACK_EN to merge adjacent half-words;
// without it every pixel becomes its own replicated-data write.
module tile_pixel_writer #(
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_addr,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  output logic        mem_write,
  input  logic        mem_waitrequest,
  output logic        busy,
  output logic [31:0] words_written
);
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] DEPTH_V = (FIFO_DEPTH_BITS+1)'(DEPTH);
  typedef struct packed {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;
  entry_t fifo_q [DEPTH];
  entry_t fifo_d [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   count_q, count_d, free;
  logic [31:0] words_written_q, words_written_d;
  entry_t last_q, last_d, head, out;
  entry_t push0_e, push1_e;
  logic push0, push1, pop, accept, fifo_empty;
  logic unused_ok;
  assign unused_ok  = ^{in_addr[0], flush};
  assign free       = DEPTH_V - count_q;
  assign fifo_empty = count_q == '0;
  assign head       = fifo_q[rd_ptr_q];
  assign pop        = !fifo_empty && !mem_waitrequest;
  assign accept     = in_valid && in_ready;
`ifdef TILE_PIXEL_WRITER_PACK_EN
  typedef enum logic {EMPTY, HALF} state_t;
  state_t state_q, state_d;
  logic [29:0] hold_word_q, hold_word_d;
  logic [15:0] hold_data_q, hold_data_d;
  logic flush_req_q, flush_req_d;
  entry_t lo_hold, hi_new;
  assign in_ready = !reset && !flush_req_q && free >= 2;
  assign busy     = (state_q == HALF) || !fifo_empty || flush_req_q;
  assign lo_hold  = '{word: hold_word_q, data: {16'h0, hold_data_q}, be: 4'b0011};
  assign hi_new   = '{word: in_addr[31:2], data: {in_data, 16'h0}, be: 4'b1100};
  always_comb begin
    state_d     = state_q;
    hold_word_d = hold_word_q;
    hold_data_d = hold_data_q;
    flush_req_d = flush_req_q;
    push0       = 1'b0;
    push1       = 1'b0;
    push0_e     = lo_hold;
    push1_e     = hi_new;
    if (flush_req_q) begin
      if (free >= 1) begin
        flush_req_d = 1'b0;
        push0       = state_q == HALF;
        state_d     = EMPTY;
      end
    end else begin
      flush_req_d = flush;
      if (accept) begin
        if (state_q == HALF && in_addr[31:2] == hold_word_q && in_addr[1]) begin
          push0   = 1'b1;
          push0_e = '{word: hold_word_q, data: {in_data, hold_data_q}, be: 4'b1111};
          state_d = EMPTY;
        end else begin
          // A non-adjacent pixel first retires the held half, then behaves as if EMPTY.
          state_d     = in_addr[1] ? EMPTY : HALF;
          hold_word_d = in_addr[31:2];
          hold_data_d = in_data;
          push0       = state_q == HALF || in_addr[1];
          push1       = state_q == HALF && in_addr[1];
          push0_e     = state_q == HALF ? lo_hold : hi_new;
        end
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      hold_word_q <= '0;
      hold_data_q <= '0;
      flush_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_word_q <= hold_word_d;
      hold_data_q <= hold_data_d;
      flush_req_q <= flush_req_d;
    end
  end
`else
  assign in_ready = !reset && free >= 1;
  assign busy     = !fifo_empty;
  always_comb begin
    push0   = accept;
    push1   = 1'b0;
    push0_e = '{word: in_addr[31:2], data: {in_data, in_data}, be: in_addr[1] ? 4'b1100 : 4'b0011};
    push1_e = '0;
  end
`endif
  always_comb begin
    fifo_d = fifo_q;
    if (push0) fifo_d[wr_ptr_q] = push0_e;
    if (push1) fifo_d[wr_ptr_q + 1'b1] = push1_e;
    wr_ptr_d        = wr_ptr_q + FIFO_DEPTH_BITS'(push0) + FIFO_DEPTH_BITS'(push1);
    rd_ptr_d        = rd_ptr_q + FIFO_DEPTH_BITS'(pop);
    count_d         = count_q + (FIFO_DEPTH_BITS+1)'(push0) + (FIFO_DEPTH_BITS+1)'(push1) - (FIFO_DEPTH_BITS+1)'(pop);
    last_d          = pop ? head : last_q;
    words_written_d = words_written_q + 32'(pop);
  end
  always_ff @(posedge clock) fifo_q <= fifo_d;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      last_q          <= '0;
      words_written_q <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      last_q          <= last_d;
      words_written_q <= words_written_d;
    end
  end
  // When empty the bus fields keep showing the last entry written out.
  assign out            = fifo_empty ? last_q : head;
  assign mem_address    = {out.word, 2'b00};
  assign mem_writedata  = out.data;
  assign mem_byteenable = out.be;
  assign mem_write      = !fifo_empty;
  assign words_written  = words_written_q;
endmodule

// File: tb/tb_tile_pixel_writer.sv
// tb_tile_pixel_writer: randomized scoreboard bench for tile_pixel_writer.
module tb_tile_pixel_writer;
  logic clock = 0, reset = 1;
  logic [31:0] in_addr = 0;
  logic [15:0] in_data = 0;
  logic in_valid = 0, flush = 0, mem_waitrequest = 0;
  logic in_ready, mem_write, busy;
  logic [31:0] mem_address, mem_writedata, words_written;
  logic [3:0] mem_byteenable;
  tile_pixel_writer dut (
    .clock(clock), .reset(reset), .in_addr(in_addr), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_write(mem_write),
    .mem_waitrequest(mem_waitrequest), .busy(busy), .words_written(words_written)
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;
  wr_t exp_q[$];
  int n_cmp = 0, n_bad = 0, exp_words = 0;
  logic have = 0;
  logic [31:0] haddr = 0;
  logic [15:0] hdata = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  function automatic void emit(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t w;
    w.a = {a[31:2], 2'b00};
    w.d = d;
    w.be = be;
    exp_q.push_back(w);
    exp_words++;
  endfunction
  function automatic void model_pixel(input logic [31:0] a, input logic [15:0] d);
`ifdef TILE_PIXEL_WRITER_PACK_EN
    if (have && a[31:2] == haddr[31:2] && a[1]) begin
      emit(haddr, {d, hdata}, 4'hF);
      have = 0;
    end else begin
      if (have) emit(haddr, {16'h0, hdata}, 4'h3);
      have = 0;
      if (a[1]) emit(a, {d, 16'h0}, 4'hC);
      else begin
        have = 1;
        haddr = a;
        hdata = d;
      end
    end
`else
    emit(a, {d, d}, a[1] ? 4'hC : 4'h3);
`endif
  endfunction
  function automatic void model_flush();
`ifdef TILE_PIXEL_WRITER_PACK_EN
    if (have) emit(haddr, {16'h0, hdata}, 4'h3);
    have = 0;
`endif
  endfunction
  task automatic drive(input logic v, input logic [31:0] a, input logic [15:0] d,
                       input logic f, input logic w, output logic acc);
    @(negedge clock);
    in_valid = v;
    in_addr = a;
    in_data = d;
    flush = f;
    mem_waitrequest = w;
    #1;
    acc = v && in_ready;
    if (acc) model_pixel(a, d);
    if (f) model_flush();
  endtask
  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, acc);
  endtask
  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      idle(1);
      k++;
    end
    idle(1);
    chk("drain_queue", 64'(exp_q.size()), 0);
    chk("drain_busy", busy, 0);
  endtask
  always begin : monitor
    wr_t w;
    logic prev_stall = 0;
    logic [31:0] pa = 0, pd = 0;
    logic [3:0] pb = 0;
    @(negedge clock);
    #2;
    if (!reset && prev_stall) begin
      chk("hold_write", mem_write, 1);
      chk("hold_addr", mem_address, pa);
      chk("hold_data", mem_writedata, pd);
      chk("hold_be", mem_byteenable, pb);
    end
    prev_stall = !reset && mem_write && mem_waitrequest;
    pa = mem_address;
    pd = mem_writedata;
    pb = mem_byteenable;
    if (!reset && mem_write && !mem_waitrequest) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h be %0h, expected none", mem_address, mem_writedata, mem_byteenable);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", mem_address, w.a);
        chk("wr_data", mem_writedata, w.d);
        chk("wr_be", mem_byteenable, w.be);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    logic acc, low_seen;
    logic [31:0] pa, a;
    int i, c, base;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_words", words_written, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_data", mem_writedata, 0);
    chk("rst_be", mem_byteenable, 0);
    @(negedge clock);
    reset = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    drive(1, 32'h1000, 16'hAAAA, 0, 0, acc);
    drive(1, 32'h1002, 16'hBBBB, 0, 0, acc);
    drive(0, 0, 0, 0, 0, acc);
    chk("latency_write", mem_write, 1);
    idle(4);
    chk("words_pair", words_written, 32'(exp_words));
    drive(1, 32'h2000, 16'h0005, 0, 0, acc);
    drive(1, 32'h2008, 16'h0007, 0, 0, acc);
    idle(4);
    chk("held_busy", busy, have);
    drive(0, 0, 0, 1, 0, acc);
    drain(50);
    drive(1, 32'h3002, 16'h1234, 0, 0, acc);
    drain(50);
    base = exp_words;
    i = 0;
    c = 0;
    low_seen = 0;
    while (i < 1024 && c < 6000) begin
      drive(1, 32'(i * 2), 16'($urandom), 0, c >= 100 && c < 120, acc);
      if (c >= 100 && c < 120 && !in_ready) low_seen = 1;
      if (acc) i++;
      c++;
    end
    chk("tile_accepted", 64'(i), 1024);
    chk("tile_ready_low", low_seen, 1);
    drive(0, 0, 0, 1, 0, acc);
    drain(200);
`ifdef TILE_PIXEL_WRITER_PACK_EN
    chk("tile_words", words_written - 32'(base), 512);
`else
    chk("tile_words", words_written - 32'(base), 1024);
`endif
    pa = 32'h4000;
    for (int k = 0; k < 400; k++) begin
      a = $urandom_range(0, 1) == 1 ? pa + 2 : 32'h4000 + 32'($urandom_range(0, 31) << 1);
      drive($urandom_range(0, 9) < 7, a, 16'($urandom), $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) == 0, acc);
      if (acc) pa = a;
    end
    drive(0, 0, 0, 1, 0, acc);
    drain(200);
    chk("rand_words", words_written, 32'(exp_words));
    drive(1, 32'h5002, 16'h1111, 0, 1, acc);
    drive(1, 32'h5006, 16'h2222, 0, 1, acc);
    drive(1, 32'h500A, 16'h3333, 0, 1, acc);
    drive(1, 32'h5010, 16'h4444, 0, 1, acc);
    drive(0, 0, 0, 0, 1, acc);
    chk("pre_rst_busy", busy, 1);
    @(negedge clock);
    reset = 1;
    mem_waitrequest = 1;
    exp_q.delete();
    have = 0;
    exp_words = 0;
    @(negedge clock);
    #1;
    chk("midrst_write", mem_write, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_words", words_written, 0);
    chk("midrst_addr", mem_address, 0);
    reset = 0;
    mem_waitrequest = 0;
    idle(10);
    chk("after_rst_words", words_written, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
